// File: rtl/seg_scan_decoder_pkg.sv
// Shared definitions for the 7-segment scan decoder.
//   - state_t      : decoder FSM states (SYNC, COLLECT, COMMIT)
//   - seg_pattern(): hex nibble -> active-low segment byte {a,b,c,d,e,f,g,dp},
//                    with dp always 1 (off)
package seg_scan_decoder_pkg;

    typedef enum logic [1:0] {
        SYNC    = 2'd0,
        COLLECT = 2'd1,
        COMMIT  = 2'd2
    } state_t;

    localparam int DIGITS = 8;

    function automatic logic [7:0] seg_pattern(input logic [3:0] nibble);
        logic [7:0] pat;
        case (nibble)
            4'h0:    pat = 8'h03;
            4'h1:    pat = 8'h9F;
            4'h2:    pat = 8'h25;
            4'h3:    pat = 8'h0D;
            4'h4:    pat = 8'h99;
            4'h5:    pat = 8'h49;
            4'h6:    pat = 8'h41;
            4'h7:    pat = 8'h1F;
            4'h8:    pat = 8'h01;
            4'h9:    pat = 8'h09;
            4'hA:    pat = 8'h11;
            4'hB:    pat = 8'hC1;
            4'hC:    pat = 8'h63;
            4'hD:    pat = 8'h85;
            4'hE:    pat = 8'h61;
            default: pat = 8'h71;
        endcase
        return pat;
    endfunction

endpackage

// File: rtl/seg_scan_decoder_decode.sv
// Combinational segment-pattern decoder.
//   seg    in  7  segment bits {a..g}, active-low (dp already stripped)
//   nibble out 4  decoded hex value, 0 when no pattern matches
//   hit    out 1  high when seg matches one of the 16 hex glyphs
module seg_pattern_decode (
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       hit
);
    import seg_scan_decoder_pkg::*;

    logic [7:0] pat;

    // The 16 glyphs are distinct in bits a..g, so first match is the only match.
    always_comb begin
        nibble = 4'h0;
        hit    = 1'b0;
        pat    = 8'h00;
        for (int i = 0; i < 16; i++) begin
            pat = seg_pattern(4'(i));
            if (!hit && (seg == pat[7:1])) begin
                hit    = 1'b1;
                nibble = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for an 8-digit multiplexed 7-segment scan bus.
// Watches (which, seg), samples each digit once it has been stable for
// SETTLE_CYCLES, decodes it to a nibble and rebuilds the 32-bit value shown.
//   clk        in   1   system clock
//   rst        in   1   synchronous reset, active-high
//   which      in   3   digit select, 0 = most significant digit
//   seg        in   8   segments, active-low {a,b,c,d,e,f,g,dp}; dp ignored
//   data       out  32  last good frame; digit k lives in data[31-4k -: 4]
//   data_valid out  1   one-cycle pulse when data is updated
//   frame_err  out  1   one-cycle pulse when a frame is discarded
//   locked     out  1   high while aligned to the scan (not in SYNC)
module seg_scan_decoder #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  which,
    input  logic [7:0]  seg,
    output logic [31:0] data,
    output logic        data_valid,
    output logic        frame_err,
    output logic        locked
);
    import seg_scan_decoder_pkg::*;

    localparam int SETTLE_W = $clog2(SETTLE_CYCLES + 1);
    localparam int DWELL_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SETTLE_W-1:0] SETTLE_MAX  = SETTLE_W'(SETTLE_CYCLES);
    localparam logic [DWELL_W-1:0]  TIMEOUT_MAX = DWELL_W'(TIMEOUT_CYCLES);

    // Decimal point carries no digit information.
    logic dp_unused;
    assign dp_unused = seg[0];

    // Input stage and one-cycle-delayed copies for change detection.
    logic [2:0] which_q, which_p;
    logic [6:0] seg_q, seg_p;

    logic [SETTLE_W-1:0] settle_cnt;
    logic [DWELL_W-1:0]  dwell_cnt;
    logic                sampled;

    logic which_change;
    logic any_change;
    logic sample;
    logic timeout;

    logic [3:0] nibble;
    logic       hit;

    // FSM state and datapath registers with their next values.
    state_t      state, state_n;
    logic [2:0]  exp_digit, exp_digit_n;
    logic        bad, bad_n;
    logic [31:0] shadow, shadow_n;
    logic [31:0] data_n;
    logic        data_valid_n;
    logic        frame_err_n;
    logic [4:0]  slot;

    assign which_change = (which_q != which_p);
    assign any_change   = which_change || (seg_q != seg_p);
    // A change in the same cycle as settle-complete suppresses the sample.
    assign sample  = !any_change && !sampled && (settle_cnt == SETTLE_MAX);
    assign timeout = (dwell_cnt == TIMEOUT_MAX);
    assign locked  = (state != SYNC);

    seg_pattern_decode u_decode (
        .seg    (seg_q),
        .nibble (nibble),
        .hit    (hit)
    );

    // Input registers, settle/dwell counters, one-sample-per-dwell flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            which_q    <= 3'd0;
            seg_q      <= 7'd0;
            which_p    <= 3'd0;
            seg_p      <= 7'd0;
            settle_cnt <= '0;
            dwell_cnt  <= '0;
            sampled    <= 1'b0;
        end else begin
            which_q <= which;
            seg_q   <= seg[7:1];
            which_p <= which_q;
            seg_p   <= seg_q;

            if (any_change)
                settle_cnt <= '0;
            else if (settle_cnt != SETTLE_MAX)
                settle_cnt <= settle_cnt + 1'b1;

            if (which_change)
                dwell_cnt <= '0;
            else if (dwell_cnt != TIMEOUT_MAX)
                dwell_cnt <= dwell_cnt + 1'b1;

            // Only a new digit re-arms sampling; segment glitches later in
            // the same dwell are ignored.
            if (which_change)
                sampled <= 1'b0;
            else if (sample)
                sampled <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SYNC;
            exp_digit  <= 3'd0;
            bad        <= 1'b0;
            shadow     <= 32'd0;
            data       <= 32'd0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            state      <= state_n;
            exp_digit  <= exp_digit_n;
            bad        <= bad_n;
            shadow     <= shadow_n;
            data       <= data_n;
            data_valid <= data_valid_n;
            frame_err  <= frame_err_n;
        end
    end

    always_comb begin
        state_n      = state;
        exp_digit_n  = exp_digit;
        bad_n        = bad;
        shadow_n     = shadow;
        data_n       = data;
        data_valid_n = 1'b0;
        frame_err_n  = 1'b0;
        // Digit 0 occupies the top nibble.
        slot         = {3'd7 - exp_digit, 2'b00};

        case (state)
            SYNC: begin
                if (which_change && (which_q == 3'd0)) begin
                    state_n     = COLLECT;
                    exp_digit_n = 3'd0;
                    bad_n       = 1'b0;
                end
            end

            COLLECT: begin
                if (timeout) begin
                    frame_err_n = 1'b1;
                    state_n     = SYNC;
                end else if (sample) begin
                    if (which_q == exp_digit) begin
                        shadow_n[slot +: 4] = nibble;
                        bad_n       = bad | !hit;
                        exp_digit_n = exp_digit + 3'd1;
                        if (which_q == 3'(DIGITS - 1))
                            state_n = COMMIT;
                    end else begin
                        frame_err_n = 1'b1;
                        state_n     = SYNC;
                    end
                end
            end

            COMMIT: begin
                if (!bad) begin
                    data_n       = shadow;
                    data_valid_n = 1'b1;
                end else begin
                    frame_err_n = 1'b1;
                end
                // Expect digit 0 next; any other digit surfaces as a
                // sequence mismatch and drops back to SYNC.
                state_n     = COLLECT;
                exp_digit_n = 3'd0;
                bad_n       = 1'b0;
            end

            default: begin
                state_n = SYNC;
            end
        endcase
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
module tb_seg_scan_decoder;

    localparam int TIMEOUT = 4000;
    localparam int DWELL   = 20;

    logic        clk;
    logic        rst;
    logic [2:0]  which;
    logic [7:0]  seg;
    logic [31:0] data;
    logic        data_valid;
    logic        frame_err;
    logic        locked;

    int vectors     = 0;
    int miscompares = 0;
    int dv_cnt      = 0;
    int fe_cnt      = 0;
    int dv_base;
    int fe_base;

    logic [31:0] exp_q[$];

    // Reference glyph table, active-low {a..g,dp}, dp off.
    logic [7:0] lut [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                             8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

    seg_scan_decoder #(
        .SETTLE_CYCLES  (4),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .which      (which),
        .seg        (seg),
        .data       (data),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .locked     (locked)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Driver tasks: inputs change on the falling edge.
    task automatic drive(input logic [2:0] w, input logic [7:0] s, input int n);
        which = w;
        seg   = s;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_digit(input int k, input logic [7:0] pat, input int dwell, input bit glitch);
        if (glitch) begin
            drive(3'(k), 8'hFE, 2);          // not a glyph: must not be sampled
            drive(3'(k), pat, 10);
            drive(3'(k), 8'h9F, 2);          // valid glyph after the sample
            drive(3'(k), pat, dwell - 14);
        end else begin
            drive(3'(k), pat, dwell);
        end
    endtask

    task automatic send_frame(input logic [31:0] v, input int dwell, input int blank_digit,
                              input int skip_digit, input int first, input bit glitch);
        logic [3:0] nib;
        logic [7:0] pat;
        for (int k = first; k < 8; k++) begin
            if (k != skip_digit) begin
                nib = v[31-4*k -: 4];
                pat = (k == blank_digit) ? 8'hFF : lut[nib];
                send_digit(k, pat, dwell, glitch);
            end
        end
    endtask

    task automatic mark;
        dv_base = dv_cnt;
        fe_base = fe_cnt;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Scoreboard: every data_valid must match the next expected frame.
    always @(negedge clk) begin
        if (!rst) begin
            if (data_valid || frame_err)
                check("pulse_exclusive", {31'd0, data_valid & frame_err}, 32'd0);
            if (data_valid) begin
                dv_cnt++;
                check("dv_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0)
                    check("dv_data", data, exp_q.pop_front());
            end
            if (frame_err)
                fe_cnt++;
        end
    end

    initial begin
        rst   = 1'b1;
        which = 3'd7;
        seg   = lut[0];
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_data", data, 32'd0);
        check("rst_dv", {31'd0, data_valid}, 32'd0);
        check("rst_fe", {31'd0, frame_err}, 32'd0);
        check("rst_locked", {31'd0, locked}, 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // 1. Full frames of 0x20241204
        mark();
        exp_q.push_back(32'h2024_1204);
        send_frame(32'h2024_1204, 2001, -1, -1, 0, 1'b0);
        check("t1_dv_cnt", 32'(dv_cnt - dv_base), 32'd1);
        check("t1_data", data, 32'h2024_1204);
        check("t1_locked", {31'd0, locked}, 32'd1);
        exp_q.push_back(32'h2024_1204);
        send_frame(32'h2024_1204, DWELL, -1, -1, 0, 1'b0);
        check("t1_dv_cnt2", 32'(dv_cnt - dv_base), 32'd2);
        check("t1_fe_cnt", 32'(fe_cnt - fe_base), 32'd0);

        // 2. Start mid-scan at digit 3
        do_reset();
        mark();
        send_frame(32'h9999_9999, DWELL, -1, -1, 3, 1'b0);
        check("t2_no_dv", 32'(dv_cnt - dv_base), 32'd0);
        check("t2_unlocked", {31'd0, locked}, 32'd0);
        check("t2_data_clear", data, 32'd0);
        exp_q.push_back(32'hDEAD_BEEF);
        send_frame(32'hDEAD_BEEF, DWELL, -1, -1, 0, 1'b0);
        check("t2_dv_cnt", 32'(dv_cnt - dv_base), 32'd1);
        check("t2_data", data, 32'hDEAD_BEEF);
        check("t2_fe_cnt", 32'(fe_cnt - fe_base), 32'd0);

        // 3. Blank digit 5 discards the frame
        mark();
        send_frame(32'h1357_9BDF, DWELL, 5, -1, 0, 1'b0);
        check("t3_fe_cnt", 32'(fe_cnt - fe_base), 32'd1);
        check("t3_no_dv", 32'(dv_cnt - dv_base), 32'd0);
        check("t3_data_kept", data, 32'hDEAD_BEEF);
        check("t3_locked", {31'd0, locked}, 32'd1);
        exp_q.push_back(32'h1357_9BDF);
        send_frame(32'h1357_9BDF, DWELL, -1, -1, 0, 1'b0);
        check("t3_dv_cnt", 32'(dv_cnt - dv_base), 32'd1);
        check("t3_data", data, 32'h1357_9BDF);

        // 4. Skipped digit 4 breaks the frame; relock at next digit 0
        mark();
        send_frame(32'hCAFE_0042, DWELL, -1, 4, 0, 1'b0);
        check("t4_fe_cnt", 32'(fe_cnt - fe_base), 32'd1);
        check("t4_unlocked", {31'd0, locked}, 32'd0);
        check("t4_no_dv", 32'(dv_cnt - dv_base), 32'd0);
        check("t4_data_kept", data, 32'h1357_9BDF);
        exp_q.push_back(32'hCAFE_0042);
        send_frame(32'hCAFE_0042, DWELL, -1, -1, 0, 1'b0);
        check("t4_dv_cnt", 32'(dv_cnt - dv_base), 32'd1);
        check("t4_data", data, 32'hCAFE_0042);
        check("t4_relocked", {31'd0, locked}, 32'd1);

        // 5. Short glitches before and after each sample
        mark();
        exp_q.push_back(32'h89AB_CDEF);
        send_frame(32'h89AB_CDEF, DWELL, -1, -1, 0, 1'b1);
        check("t5_dv_cnt", 32'(dv_cnt - dv_base), 32'd1);
        check("t5_fe_cnt", 32'(fe_cnt - fe_base), 32'd0);
        check("t5_data", data, 32'h89AB_CDEF);

        // 6. Stall on digit 2, then reset mid-frame
        mark();
        drive(3'd0, lut[4'h8], DWELL);
        drive(3'd1, lut[4'h9], DWELL);
        drive(3'd2, lut[4'hA], TIMEOUT + 200);
        check("t6_fe_cnt", 32'(fe_cnt - fe_base), 32'd1);
        check("t6_unlocked", {31'd0, locked}, 32'd0);
        check("t6_data_kept", data, 32'h89AB_CDEF);
        mark();
        drive(3'd0, lut[4'h1], DWELL);
        drive(3'd1, lut[4'h2], DWELL);
        check("t6_relocked", {31'd0, locked}, 32'd1);
        drive(3'd2, lut[4'h3], 8);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst_data", data, 32'd0);
        check("t6_rst_dv", {31'd0, data_valid}, 32'd0);
        check("t6_rst_fe", {31'd0, frame_err}, 32'd0);
        check("t6_rst_locked", {31'd0, locked}, 32'd0);
        rst = 1'b0;
        drive(3'd3, lut[4'h4], DWELL);
        check("t6_post_rst_unlocked", {31'd0, locked}, 32'd0);
        check("t6_no_pulses", 32'(dv_cnt - dv_base + fe_cnt - fe_base), 32'd0);

        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
